// File: rtl/step_stream_scheduler.sv
// Round-robin scheduler sharing one stepping stream device among NREQ burst requesters.
// Each value costs one RUN cycle (advance + capture) followed by a HOLD cycle until consumed.
module step_stream_scheduler #(
  parameter  int NREQ  = 4,
  parameter  int CNT_W = 4,
  parameter  int DW    = 8,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*CNT_W-1:0] req_count,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DW-1:0]         rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_last,
  output logic                  dev_adv,
  input  logic [DW-1:0]         dev_out,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [IDW-1:0] id;
    logic           last;
  } rsp_t;

  state_t                     r_state;
  logic [IDW-1:0]             r_ptr;
  logic [CNT_W-1:0]           r_rem;
  rsp_t                       r_rsp;

  logic [NREQ-1:0][CNT_W-1:0] w_cnt;
  logic [2*NREQ-1:0]          w_dbl;
  logic [NREQ-1:0]            w_rot;
  logic [IDW-1:0]             w_off;
  logic [IDW:0]               w_sum;
  logic [IDW-1:0]             w_gnt_idx;
  logic [IDW-1:0]             w_nxt_ptr;
  logic                       w_gnt_vld;

  assign w_cnt     = req_count;
  assign w_gnt_vld = |req_valid;

  // Rotate so rr_ptr sits at bit 0, pick the lowest set bit, then rotate the offset back.
  always_comb begin
    w_dbl = {req_valid, req_valid} >> r_ptr;
    w_rot = w_dbl[NREQ-1:0];
    w_off = '0;
    for (int j = NREQ-1; j >= 0; j--) begin
      if (w_rot[j]) w_off = IDW'(j);
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= (IDW+1)'(NREQ)) w_sum = w_sum - (IDW+1)'(NREQ);
    w_gnt_idx = w_sum[IDW-1:0];
  end

  assign w_nxt_ptr = (w_gnt_idx == IDW'(NREQ-1)) ? '0 : w_gnt_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_rem   <= '0;
      r_rsp   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt_vld) begin
            r_rsp.id <= w_gnt_idx;
            r_rem    <= w_cnt[w_gnt_idx];
            r_ptr    <= w_nxt_ptr;
            // A zero-length burst is consumed here without ever leaving IDLE.
            if (w_cnt[w_gnt_idx] != '0) r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_rsp.data <= dev_out;
          r_rsp.last <= (r_rem == CNT_W'(1));
          r_state    <= S_HOLD;
        end
        S_HOLD: begin
          if (rsp_ready) begin
            r_rem   <= r_rem - 1'b1;
            r_state <= (r_rem == CNT_W'(1)) ? S_IDLE : S_RUN;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes are masked while reset is held so nothing is granted, advanced or handed out.
  assign req_ready = (rst && r_state == S_IDLE && w_gnt_vld) ? (NREQ'(1) << w_gnt_idx) : '0;
  assign dev_adv   = rst && (r_state == S_RUN);
  assign rsp_valid = rst && (r_state == S_HOLD);
  assign busy      = (r_state != S_IDLE);
  assign rsp_data  = r_rsp.data;
  assign rsp_id    = r_rsp.id;
  assign rsp_last  = r_rsp.last;

endmodule
